vit_prbs_checker: RTL and testbench
===================================

Name: vit_prbs_checker

Overview:
- Receive-side partner of the hardware PRBS frame source that feeds vit_enc.
- Sits on the vit_dec output stream (osop/oval/oeop/odat).
- Regenerates the same per-frame PRBS locally, compares it bit-by-bit against the decoded data, and reports per-frame and cumulative error statistics.
- Used for on-silicon and long-run BER/FER measurement without a software reference queue.

Parameters:
- pPRBS_W, 15, LFSR length in bits.
- pPRBS_POLY, 'h6000, tap mask for x^15+x^14+1; bit k set means state bit k feeds the parity.
- pPRBS_SEED, 'h7FFF, LFSR load value at every sop; must be nonzero.
- pFRM_CNT_W, 16, width of per-frame bit and error counters.
- pACC_CNT_W, 32, width of cumulative counters.

Ports:
- iclk  in  1  clock
- ireset  in  1  synchronous reset, active-low
- iclkena  in  1  clock enable; all state holds when low
- iclr  in  1  clear cumulative counters
- isop  in  1  first decoded bit of frame
- ival  in  1  decoded bit valid
- ieop  in  1  last decoded bit of frame
- idat  in  1  decoded bit
- odone  out  1  one-cycle pulse: frame results valid
- oframe_bits  out  pFRM_CNT_W  bits in completed frame
- oframe_errs  out  pFRM_CNT_W  bit errors in completed frame
- oframe_bad  out  1  oframe_errs != 0
- ofrm_total  out  pACC_CNT_W  frames completed since clear
- ofrm_err_total  out  pACC_CNT_W  frames with at least one error
- obit_err_total  out  pACC_CNT_W  total bit errors
- oprot_err  out  1  sticky protocol violation flag; cleared by iclr

Behaviour:
- Reset (ireset=0 at a clock edge, regardless of iclkena): all outputs and counters go to 0, FSM goes to IDLE, LFSR is loaded with pPRBS_SEED.
- All updates occur only when iclkena=1. A beat means ival=1.
- LFSR, Fibonacci form: reference bit = s[pPRBS_W-1]; next s = {s[pPRBS_W-2:0], ^(s & pPRBS_POLY)}.
- On a sop beat the comparison uses pPRBS_SEED's MSB, and the LFSR loads the seed already advanced by one step.
- Every subsequent in-frame beat compares against the current MSB, then advances the LFSR.
- FSM IDLE:
  - sop beat: start frame with bits=1 and errs=(idat != ref); go to FRAME.
  - sop & eop on the same beat: a 1-bit frame; complete it and stay in IDLE.
  - non-sop beat: ignored; set oprot_err.
- FSM FRAME:
  - Normal beat: bits++, errs += mismatch.
  - eop beat: include that bit, complete the frame, go to IDLE.
  - sop beat (missing eop): discard the partial frame without completing it, set oprot_err, restart a new frame from this beat.
- Frame completion: registered one cycle after the eop beat.
  - odone=1 for exactly one enabled cycle.
  - oframe_bits, oframe_errs and oframe_bad are valid together and held until the next completion.
  - ofrm_total += 1; ofrm_err_total += oframe_bad; obit_err_total += oframe_errs. All updates appear in the same cycle as odone.
- Per-frame counters saturate at all-ones. Bits keep being checked after saturation.
- Cumulative counters saturate at all-ones. They never wrap.
- iclr alone: cumulative counters and oprot_err go to 0 on the next edge. Per-frame state and any in-progress frame are unaffected.
- iclr in the same cycle as a completion update: counters load that frame's contribution, i.e. clear then add. oprot_err clears.
- ival=0 cycles inside a frame have no effect. Gaps of any length are allowed.
- ireset low mid-frame: the frame is dropped with no odone. The next frame must start with sop.

Decomposition:
- Package vit_prbs_pkg holds:
  - default polynomial and seed constants;
  - FSM state enum (IDLE, FRAME);
  - function prbs_next(state, poly) returning the next LFSR state, shared with the generator side.
- One sub-module, vit_prbs_lfsr: load/advance LFSR, reused by the PRBS frame source.

Test Plan:
- Error-free: 4 frames of 1010 bits, idat = PRBS from seed 'h7FFF -> 4 odone pulses; oframe_bits=1010, oframe_errs=0; ofrm_total=4, ofrm_err_total=0, obit_err_total=0.
- Injected errors: invert bits 0, 500 and 1009 of frame 2 of 3 -> frame 2 oframe_errs=3, oframe_bad=1; ofrm_err_total=1, obit_err_total=3.
- Protocol faults:
  - 10 valid beats outside a frame -> oprot_err=1, no odone.
  - sop at beat 200 of a 1010-bit frame -> first frame discarded; next completion reports that frame's actual bit count; ofrm_total increments once.
- 1-bit frame: sop=eop=1 with idat=1 (matches seed MSB) -> odone next cycle, oframe_bits=1, oframe_errs=0.
- Clear and enable: iclr coincident with odone of a frame having 2 errors -> obit_err_total=2, ofrm_total=1. iclkena=0 for 5 cycles mid-frame with ival=1 -> no count change.
- Saturation and reset: pACC_CNT_W=4, 20 errored frames -> ofrm_err_total=15. ireset low at beat 300 -> all outputs 0 and no odone for that frame.

Source files
------------

// File: rtl/vit_prbs_pkg.sv
// Shared PRBS definitions for the Viterbi test-frame source and its receive-side checker.
package vit_prbs_pkg;

    localparam int PRBS_MAX_W = 32;

    localparam logic [PRBS_MAX_W-1:0] PRBS_POLY_DEF = 32'h0000_6000;
    localparam logic [PRBS_MAX_W-1:0] PRBS_SEED_DEF = 32'h0000_7FFF;

    typedef enum logic {IDLE, FRAME} frm_state_t;

    // Fibonacci step: shift left, feed parity of tapped bits into bit 0, keep only w bits.
    function automatic logic [PRBS_MAX_W-1:0] prbs_next(
        input logic [PRBS_MAX_W-1:0] s,
        input logic [PRBS_MAX_W-1:0] poly,
        input int                    w
    );
        logic [PRBS_MAX_W-1:0] nxt;
        nxt = {s[PRBS_MAX_W-2:0], ^(s & poly)};
        for (int i = 0; i < PRBS_MAX_W; i++) begin
            if (i >= w) nxt[i] = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vit_prbs_lfsr.sv
// Loadable PRBS register: load jumps to the seed already advanced once, step advances one bit.
module vit_prbs_lfsr
    import vit_prbs_pkg::*;
#(
    parameter int                    pPRBS_W    = 15,
    parameter logic [PRBS_MAX_W-1:0] pPRBS_POLY = PRBS_POLY_DEF,
    parameter logic [PRBS_MAX_W-1:0] pPRBS_SEED = PRBS_SEED_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic load,
    input  logic step,
    output logic msb
);

    localparam logic [pPRBS_W-1:0] SEED      = pPRBS_W'(pPRBS_SEED);
    localparam logic [pPRBS_W-1:0] SEED_NEXT = pPRBS_W'(prbs_next(pPRBS_SEED, pPRBS_POLY, pPRBS_W));

    logic [pPRBS_W-1:0] state;
    logic [pPRBS_W-1:0] state_adv;

    assign state_adv = pPRBS_W'(prbs_next(PRBS_MAX_W'(state), pPRBS_POLY, pPRBS_W));
    assign msb       = state[pPRBS_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (ena) begin
            if (load)      state <= SEED_NEXT;
            else if (step) state <= state_adv;
        end
    end

endmodule

// File: rtl/vit_prbs_checker.sv
// Compares decoded frames against the locally regenerated PRBS and keeps per-frame and
// cumulative BER/FER statistics.
module vit_prbs_checker
    import vit_prbs_pkg::*;
#(
    parameter int                    pPRBS_W    = 15,
    parameter logic [PRBS_MAX_W-1:0] pPRBS_POLY = PRBS_POLY_DEF,
    parameter logic [PRBS_MAX_W-1:0] pPRBS_SEED = PRBS_SEED_DEF,
    parameter int                    pFRM_CNT_W = 16,
    parameter int                    pACC_CNT_W = 32
)(
    input  logic                  iclk,
    input  logic                  ireset,
    input  logic                  iclkena,
    input  logic                  iclr,
    input  logic                  isop,
    input  logic                  ival,
    input  logic                  ieop,
    input  logic                  idat,
    output logic                  odone,
    output logic [pFRM_CNT_W-1:0] oframe_bits,
    output logic [pFRM_CNT_W-1:0] oframe_errs,
    output logic                  oframe_bad,
    output logic [pACC_CNT_W-1:0] ofrm_total,
    output logic [pACC_CNT_W-1:0] ofrm_err_total,
    output logic [pACC_CNT_W-1:0] obit_err_total,
    output logic                  oprot_err
);

    localparam logic                  SEED_MSB = pPRBS_SEED[pPRBS_W-1];
    localparam logic [pFRM_CNT_W-1:0] FRM_ONE  = pFRM_CNT_W'(1);
    localparam logic [pACC_CNT_W-1:0] ACC_MAX  = '1;

    function automatic logic [pFRM_CNT_W-1:0] frm_sat_inc(
        input logic [pFRM_CNT_W-1:0] a,
        input logic                  inc
    );
        if (!inc || (&a)) return a;
        return a + FRM_ONE;
    endfunction

    function automatic logic [pACC_CNT_W-1:0] acc_sat_add(
        input logic [pACC_CNT_W-1:0] a,
        input logic [pFRM_CNT_W-1:0] b
    );
        logic [63:0] sum;
        sum = 64'(a) + 64'(b);
        if (sum > 64'(ACC_MAX)) return ACC_MAX;
        return sum[pACC_CNT_W-1:0];
    endfunction

    frm_state_t              state_p0, state_nxt;
    logic [pFRM_CNT_W-1:0]   bits_p0, errs_p0, bits_nxt, errs_nxt;
    logic                    lfsr_msb, ref_bit, mis, load, step, complete, prot_set;

    logic                    vld_p1, bad_p1, prot_p1;
    logic [pFRM_CNT_W-1:0]   bits_p1, errs_p1;
    logic [pACC_CNT_W-1:0]   frm_total_p1, frm_err_total_p1, bit_err_total_p1;
    logic [pACC_CNT_W-1:0]   frm_total_nxt, frm_err_total_nxt, bit_err_total_nxt;
    logic [pACC_CNT_W-1:0]   frm_base, err_base, bit_base;

    vit_prbs_lfsr #(
        .pPRBS_W    (pPRBS_W),
        .pPRBS_POLY (pPRBS_POLY),
        .pPRBS_SEED (pPRBS_SEED)
    ) u_lfsr (
        .clk   (iclk),
        .rst_n (ireset),
        .ena   (iclkena),
        .load  (load),
        .step  (step),
        .msb   (lfsr_msb)
    );

    // p0: frame tracking; a sop always restarts, even if it truncates an open frame
    always_comb begin
        state_nxt = state_p0;
        bits_nxt  = bits_p0;
        errs_nxt  = errs_p0;
        load      = 1'b0;
        step      = 1'b0;
        complete  = 1'b0;
        prot_set  = 1'b0;
        ref_bit   = isop ? SEED_MSB : lfsr_msb;
        mis       = idat ^ ref_bit;
        if (ival) begin
            if (isop) begin
                prot_set  = (state_p0 == FRAME);
                load      = 1'b1;
                bits_nxt  = FRM_ONE;
                errs_nxt  = pFRM_CNT_W'(mis);
                complete  = ieop;
                state_nxt = ieop ? IDLE : FRAME;
            end else if (state_p0 == FRAME) begin
                step     = 1'b1;
                bits_nxt = frm_sat_inc(bits_p0, 1'b1);
                errs_nxt = frm_sat_inc(errs_p0, mis);
                if (ieop) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end else begin
                prot_set = 1'b1;
            end
        end
    end

    // p1: completion results; clear happens before this frame's contribution is added
    always_comb begin
        frm_base          = iclr ? '0 : frm_total_p1;
        err_base          = iclr ? '0 : frm_err_total_p1;
        bit_base          = iclr ? '0 : bit_err_total_p1;
        frm_total_nxt     = frm_base;
        frm_err_total_nxt = err_base;
        bit_err_total_nxt = bit_base;
        if (complete) begin
            frm_total_nxt     = acc_sat_add(frm_base, FRM_ONE);
            frm_err_total_nxt = acc_sat_add(err_base, pFRM_CNT_W'(|errs_nxt));
            bit_err_total_nxt = acc_sat_add(bit_base, errs_nxt);
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state_p0         <= IDLE;
            bits_p0          <= '0;
            errs_p0          <= '0;
            vld_p1           <= 1'b0;
            bits_p1          <= '0;
            errs_p1          <= '0;
            bad_p1           <= 1'b0;
            frm_total_p1     <= '0;
            frm_err_total_p1 <= '0;
            bit_err_total_p1 <= '0;
            prot_p1          <= 1'b0;
        end else if (iclkena) begin
            state_p0         <= state_nxt;
            bits_p0          <= bits_nxt;
            errs_p0          <= errs_nxt;
            vld_p1           <= complete;
            if (complete) begin
                bits_p1 <= bits_nxt;
                errs_p1 <= errs_nxt;
                bad_p1  <= |errs_nxt;
            end
            frm_total_p1     <= frm_total_nxt;
            frm_err_total_p1 <= frm_err_total_nxt;
            bit_err_total_p1 <= bit_err_total_nxt;
            prot_p1          <= prot_set | (prot_p1 & ~iclr);
        end
    end

    assign odone          = vld_p1;
    assign oframe_bits    = bits_p1;
    assign oframe_errs    = errs_p1;
    assign oframe_bad     = bad_p1;
    assign ofrm_total     = frm_total_p1;
    assign ofrm_err_total = frm_err_total_p1;
    assign obit_err_total = bit_err_total_p1;
    assign oprot_err      = prot_p1;

endmodule

// File: tb/tb_vit_prbs_checker.sv
// Scoreboard bench for vit_prbs_checker: a driver issues frames and queues expected results,
// a monitor pops and compares on every odone (also against a 4-bit-accumulator instance).
module tb_vit_prbs_checker;

    logic iclk = 1'b0;
    logic ireset = 1'b0, iclkena = 1'b0, iclr = 1'b0;
    logic isop = 1'b0, ival = 1'b0, ieop = 1'b0, idat = 1'b0;

    logic        odone, oframe_bad, oprot_err;
    logic [15:0] oframe_bits, oframe_errs;
    logic [31:0] ofrm_total, ofrm_err_total, obit_err_total;

    logic        s_odone, s_oframe_bad, s_oprot_err;
    logic [15:0] s_oframe_bits, s_oframe_errs;
    logic [3:0]  s_ofrm_total, s_ofrm_err_total, s_obit_err_total;

    vit_prbs_checker #(
        .pPRBS_W(15), .pPRBS_POLY('h6000), .pPRBS_SEED('h7FFF),
        .pFRM_CNT_W(16), .pACC_CNT_W(32)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iclr(iclr),
        .isop(isop), .ival(ival), .ieop(ieop), .idat(idat),
        .odone(odone), .oframe_bits(oframe_bits), .oframe_errs(oframe_errs),
        .oframe_bad(oframe_bad), .ofrm_total(ofrm_total), .ofrm_err_total(ofrm_err_total),
        .obit_err_total(obit_err_total), .oprot_err(oprot_err)
    );

    vit_prbs_checker #(
        .pPRBS_W(15), .pPRBS_POLY('h6000), .pPRBS_SEED('h7FFF),
        .pFRM_CNT_W(16), .pACC_CNT_W(4)
    ) dut_sat (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iclr(iclr),
        .isop(isop), .ival(ival), .ieop(ieop), .idat(idat),
        .odone(s_odone), .oframe_bits(s_oframe_bits), .oframe_errs(s_oframe_errs),
        .oframe_bad(s_oframe_bad), .ofrm_total(s_ofrm_total), .ofrm_err_total(s_ofrm_err_total),
        .obit_err_total(s_obit_err_total), .oprot_err(s_oprot_err)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int bits;
        int errs;
        bit bad;
        int ft;
        int fet;
        int bet;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   ref_seq [0:1199];
    int   m_ft = 0, m_fet = 0, m_bet = 0;
    bit   m_prot = 1'b0, m_in_frame = 1'b0;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference sequence from the recurrence o[n+W] = XOR of o[n+W-1-k] over taps k,
    // with the first W bits being the seed read MSB first.
    task automatic gen_ref();
        logic [14:0] seed, poly;
        bit acc;
        seed = 15'h7FFF;
        poly = 15'h6000;
        for (int k = 0; k < 15; k++) ref_seq[k] = seed[14-k];
        for (int n = 0; n + 15 < 1200; n++) begin
            acc = 1'b0;
            for (int t = 0; t < 15; t++) if (poly[t]) acc ^= ref_seq[n+14-t];
            ref_seq[n+15] = acc;
        end
    endtask

    task automatic drive(input bit sop, input bit val, input bit eop, input bit dat,
                         input bit clr, input bit ena);
        isop = sop; ival = val; ieop = eop; idat = dat; iclr = clr; iclkena = ena;
        @(posedge iclk);
        #1;
        if (clr && ena) begin
            m_ft = 0; m_fet = 0; m_bet = 0; m_prot = 1'b0;
        end
    endtask

    task automatic gap();
        drive(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
    endtask

    task automatic send_frame(input int n, input int trunc, input int ia, input int ib,
                              input int ic, input bit clr_eop, input int stall_at);
        int   errs, sent;
        bit   d, last;
        exp_t e;
        errs = 0;
        sent = (trunc > 0) ? trunc : n;
        if (m_in_frame) m_prot = 1'b1;
        for (int i = 0; i < sent; i++) begin
            if ($urandom_range(0, 7) == 0) gap();
            if (i == stall_at) repeat (5) drive(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
            d = ref_seq[i];
            if (i == ia || i == ib || i == ic) begin
                d = ~d;
                errs++;
            end
            last = (trunc == 0) && (i == n - 1);
            drive(i == 0, 1'b1, last, d, clr_eop && last, 1'b1);
        end
        m_in_frame = (trunc > 0);
        if (trunc == 0) begin
            m_ft++;
            if (errs > 0) m_fet++;
            m_bet += errs;
            e.bits = n; e.errs = errs; e.bad = (errs > 0);
            e.ft = m_ft; e.fet = m_fet; e.bet = m_bet;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        ireset = 1'b0; iclkena = 1'b0; ival = 1'b0; isop = 1'b0; ieop = 1'b0; iclr = 1'b0;
        @(posedge iclk);
        #1;
        ireset = 1'b1; iclkena = 1'b1;
        m_ft = 0; m_fet = 0; m_bet = 0; m_prot = 1'b0; m_in_frame = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_prot"},     64'(oprot_err),        64'(m_prot));
        check({tag, "_ft"},       64'(ofrm_total),       64'(m_ft));
        check({tag, "_fet"},      64'(ofrm_err_total),   64'(m_fet));
        check({tag, "_bet"},      64'(obit_err_total),   64'(m_bet));
        check({tag, "_sat_fet"},  64'(s_ofrm_err_total), 64'(sat15(m_fet)));
    endtask

    always @(negedge iclk) begin
        if (ireset && odone) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_odone: got odone=1 expected no completion (ofrm_total=%0d)",
                         ofrm_total);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_bits",     64'(oframe_bits),      64'(e.bits));
                check("frame_errs",     64'(oframe_errs),      64'(e.errs));
                check("frame_bad",      64'(oframe_bad),       64'(e.bad));
                check("frm_total",      64'(ofrm_total),       64'(e.ft));
                check("frm_err_total",  64'(ofrm_err_total),   64'(e.fet));
                check("bit_err_total",  64'(obit_err_total),   64'(e.bet));
                check("sat_odone",      64'(s_odone),          64'(1));
                check("sat_frm_total",  64'(s_ofrm_total),     64'(sat15(e.ft)));
                check("sat_frm_err",    64'(s_ofrm_err_total), 64'(sat15(e.fet)));
                check("sat_bit_err",    64'(s_obit_err_total), 64'(sat15(e.bet)));
            end
        end
    end

    initial begin
        int len, nerr;
        int p[3];
        gen_ref();
        repeat (2) @(posedge iclk);
        #1;
        do_reset();
        check("rst_odone", 64'(odone), 64'(0));
        check("rst_bits",  64'(oframe_bits), 64'(0));
        check("rst_errs",  64'(oframe_errs), 64'(0));
        check("rst_bad",   64'(oframe_bad), 64'(0));
        check_state("rst");

        repeat (4) send_frame(1010, 0, -1, -1, -1, 1'b0, -1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("clean");

        send_frame(1010, 0, -1, -1, -1, 1'b0, -1);
        send_frame(1010, 0, 0, 500, 1009, 1'b0, -1);
        send_frame(1010, 0, -1, -1, -1, 1'b0, -1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("inject");

        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        m_prot = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("stray");

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_state("clr");

        send_frame(1010, 200, 7, -1, -1, 1'b0, -1);
        send_frame(1010, 0, 42, -1, -1, 1'b0, -1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("resop");

        send_frame(1, 0, -1, -1, -1, 1'b0, -1);
        send_frame(50, 0, 3, 17, -1, 1'b1, -1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("clr_done");

        send_frame(300, 0, 150, -1, -1, 1'b0, 100);
        for (int f = 0; f < 6; f++) begin
            len  = $urandom_range(1, 400);
            nerr = $urandom_range(0, 3);
            for (int k = 0; k < 3; k++) p[k] = (k < nerr) ? $urandom_range(0, len - 1) : -1;
            send_frame(len, 0, p[0], p[1], p[2], 1'b0, -1);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("rand");

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (20) send_frame(8, 0, $urandom_range(0, 7), -1, -1, 1'b0, -1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("sat");
        check("sat_fet_is_15", 64'(s_ofrm_err_total), 64'(15));

        send_frame(1010, 300, 12, -1, -1, 1'b0, -1);
        do_reset();
        check("midrst_odone", 64'(odone), 64'(0));
        check("midrst_bits",  64'(oframe_bits), 64'(0));
        check("midrst_errs",  64'(oframe_errs), 64'(0));
        check_state("midrst");
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(100, 0, 5, -1, -1, 1'b0, -1);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("final");
        check("pending_odone", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
